// File: rtl/fabric_cfg_pkg.sv
// Shared configuration-fabric definitions: loader state encoding and
// control-vector sizing helpers used by loaders and switch boxes alike.
package fabric_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        PASS   = 2'd3
    } cfg_state_t;

    // Six control bits per single track and per double-track pair.
    function automatic int unsigned cfg_width(input int unsigned ws, input int unsigned wd);
        return (ws + wd / 2) * 6;
    endfunction

    function automatic int unsigned cfg_words(input int unsigned cw, input int unsigned dw);
        return (cw + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/clb_config_loader_if.sv
// Configuration word stream: upstream valid/ready input, downstream
// pass-through output and the broadcast load-start pulse.
interface clb_config_loader_if #(
    parameter int unsigned DW = 8
) ();
    logic          cfg_start;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [DW-1:0] cfg_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        output cfg_start, cfg_valid, cfg_data, out_ready,
        input  cfg_ready, out_valid, out_data
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data, out_ready,
        output cfg_ready, out_valid, out_data
    );
endinterface

// File: rtl/clb_config_loader.sv
// Per-tile configuration loader: shifts NW words into a shadow register,
// commits the switch-box control vector atomically, then forwards the chain.
module clb_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter  int unsigned WS = 8,
    parameter  int unsigned WD = 8,
    parameter  int unsigned DW = 8,
    localparam int unsigned CW = cfg_width(WS, WD),
    localparam int unsigned NW = cfg_words(CW, DW)
) (
    input  logic                       clk,
    input  logic                       rst,
    clb_config_loader_if.slave         bus,
    output logic [CW-1:0]              c,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned SW    = NW * DW;
    localparam int unsigned CNT_W = $clog2(NW + 1);

    cfg_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [SW-1:0]    r_sh,    w_sh_nxt;
    logic [CW-1:0]    r_c,     w_c_nxt;
    logic             r_done,  w_done_nxt;
    logic             w_cfg_ready;
    logic             w_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sh    <= '0;
            r_c     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sh    <= w_sh_nxt;
            r_c     <= w_c_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // A start pulse overrides everything, including an in-flight commit.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sh_nxt    = r_sh;
        w_c_nxt     = r_c;
        w_done_nxt  = 1'b0;
        w_cfg_ready = 1'b0;
        w_out_valid = 1'b0;

        if (bus.cfg_start) begin
            w_state_nxt = LOAD;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                end
                LOAD: begin
                    w_cfg_ready = 1'b1;
                    if (bus.cfg_valid) begin
                        w_sh_nxt  = {bus.cfg_data, r_sh[SW-1:DW]};
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(NW - 1)) begin
                            w_state_nxt = COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    w_c_nxt     = r_sh[CW-1:0];
                    w_done_nxt  = 1'b1;
                    w_state_nxt = PASS;
                end
                PASS: begin
                    w_cfg_ready = bus.out_ready;
                    w_out_valid = bus.cfg_valid;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ready = w_cfg_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = bus.cfg_data;
    assign c             = r_c;
    assign done          = r_done;
    assign busy          = (r_state == LOAD) || (r_state == COMMIT);

endmodule

// File: tb/tb_clb_config_loader.sv
// Directed bench for clb_config_loader: default-size and small-size tiles.
module tb_clb_config_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clb_config_loader_if #(.DW(8)) ia ();
    clb_config_loader_if #(.DW(8)) ib ();

    logic [71:0] c_a;
    logic        busy_a, done_a;
    logic [29:0] c_b;
    logic        busy_b, done_b;

    clb_config_loader #(.WS(8), .WD(8), .DW(8)) u_a (
        .clk  (clk),
        .rst  (rst),
        .bus  (ia.slave),
        .c    (c_a),
        .busy (busy_a),
        .done (done_a)
    );

    clb_config_loader #(.WS(4), .WD(2), .DW(8)) u_b (
        .clk  (clk),
        .rst  (rst),
        .bus  (ib.slave),
        .c    (c_b),
        .busy (busy_b),
        .done (done_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t tv[14];

    localparam logic [71:0] C_SEQ0  = 72'h08_07_06_05_04_03_02_01_00;
    localparam logic [71:0] C_11    = {9{8'h11}};
    localparam logic [71:0] C_SEQ20 = 72'h28_27_26_25_24_23_22_21_20;
    localparam logic [71:0] C_SEQ30 = 72'h38_37_36_35_34_33_32_31_30;

    // Loads nine words into tile A (data = base + step*k), optionally with
    // random valid gaps; counts done pulses and flags any early change of c.
    task automatic load_a(input bit do_start, input logic [7:0] base, input logic [7:0] step,
                          input bit gaps, input logic [71:0] old_c,
                          output int n_done, output bit hold_ok);
        int idx;
        int cyc;
        idx     = 0;
        cyc     = 0;
        n_done  = 0;
        hold_ok = 1'b1;
        if (do_start) begin
            ia.cfg_start = 1'b1;
            ia.cfg_valid = 1'b0;
            @(posedge clk); #1;
            ia.cfg_start = 1'b0;
        end
        while (idx < 9 && cyc < 200) begin
            ia.cfg_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ia.cfg_data  = base + 8'(step * 8'(idx));
            @(negedge clk);
            if (done_a) n_done++;
            if (c_a !== old_c) hold_ok = 1'b0;
            if (ia.cfg_valid && ia.cfg_ready) idx++;
            @(posedge clk); #1;
            cyc++;
        end
        ia.cfg_valid = 1'b0;
        chk("load_words_accepted", 72'(idx), 72'd9);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done_a) n_done++;
            if (n_done == 0 && c_a !== old_c) hold_ok = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int  nd;
        bit  hold;
        int  busy_cnt;
        logic [7:0] wb [4];

        // start, valid, data, ordy | rdy, ov, busy, done
        tv[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 1; k <= 9; k++)
            tv[k] = '{1'b0, 1'b1, 8'(k - 1), 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[10] = '{1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[11] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tv[12] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tv[13] = '{1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        ia.cfg_start = 1'b0; ia.cfg_valid = 1'b0; ia.cfg_data = 8'h00; ia.out_ready = 1'b0;
        ib.cfg_start = 1'b0; ib.cfg_valid = 1'b0; ib.cfg_data = 8'h00; ib.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_c",         c_a,                72'h0);
        chk("reset_cfg_ready", 72'(ia.cfg_ready),  72'h0);
        chk("reset_out_valid", 72'(ia.out_valid),  72'h0);
        chk("reset_busy",      72'(busy_a),        72'h0);
        chk("reset_done",      72'(done_a),        72'h0);
        chk("reset_c_small",   72'(c_b),           72'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full load followed by pass-through, one vector per cycle.
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            ia.cfg_start = tv[i].start;
            ia.cfg_valid = tv[i].valid;
            ia.cfg_data  = tv[i].data;
            ia.out_ready = tv[i].ordy;
            @(negedge clk);
            if (busy_a) busy_cnt++;
            chk($sformatf("vec%0d_cfg_ready", i), 72'(ia.cfg_ready), 72'(tv[i].e_rdy));
            chk($sformatf("vec%0d_out_valid", i), 72'(ia.out_valid), 72'(tv[i].e_ov));
            chk($sformatf("vec%0d_out_data", i),  72'(ia.out_data),  72'(tv[i].data));
            chk($sformatf("vec%0d_busy", i),      72'(busy_a),       72'(tv[i].e_busy));
            chk($sformatf("vec%0d_done", i),      72'(done_a),       72'(tv[i].e_done));
            chk($sformatf("vec%0d_c", i),         c_a,               (i <= 10) ? 72'h0 : C_SEQ0);
            @(posedge clk); #1;
        end
        ia.cfg_start = 1'b0; ia.cfg_valid = 1'b0; ia.out_ready = 1'b0;
        chk("busy_cycles", 72'(busy_cnt), 72'd10);

        // Partial load interrupted by a restart with a coincident word.
        ia.cfg_start = 1'b1;
        @(posedge clk); #1;
        ia.cfg_start = 1'b0;
        ia.cfg_valid = 1'b1;
        ia.cfg_data  = 8'h3C;
        repeat (4) begin @(posedge clk); #1; end
        ia.cfg_start = 1'b1;
        ia.cfg_data  = 8'hFF;
        @(negedge clk);
        chk("restart_cfg_ready", 72'(ia.cfg_ready), 72'h0);
        chk("restart_c_held",    c_a,               C_SEQ0);
        @(posedge clk); #1;
        ia.cfg_start = 1'b0;
        load_a(1'b0, 8'h11, 8'h00, 1'b0, C_SEQ0, nd, hold);
        chk("restart_c",       c_a,            C_11);
        chk("restart_done_n",  72'(nd),        72'd1);
        chk("restart_hold",    72'(hold),      72'd1);

        // Asynchronous reset in the middle of a load.
        ia.cfg_start = 1'b1;
        @(posedge clk); #1;
        ia.cfg_start = 1'b0;
        ia.cfg_valid = 1'b1;
        ia.cfg_data  = 8'h77;
        repeat (5) begin @(posedge clk); #1; end
        ia.cfg_valid = 1'b0;
        chk("prerst_busy", 72'(busy_a), 72'h1);
        chk("prerst_c",    c_a,         C_11);
        #2 rst = 1'b1;
        #1;
        chk("asyncrst_c",         c_a,               72'h0);
        chk("asyncrst_busy",      72'(busy_a),       72'h0);
        chk("asyncrst_cfg_ready", 72'(ia.cfg_ready), 72'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        load_a(1'b1, 8'h20, 8'h01, 1'b0, 72'h0, nd, hold);
        chk("postrst_c",      c_a,      C_SEQ20);
        chk("postrst_done_n", 72'(nd),  72'd1);

        // Random valid gaps must not change the committed result.
        load_a(1'b1, 8'h30, 8'h01, 1'b1, C_SEQ20, nd, hold);
        chk("gaps_c",      c_a,       C_SEQ30);
        chk("gaps_done_n", 72'(nd),   72'd1);
        chk("gaps_hold",   72'(hold), 72'd1);

        // Small tile: padding bits of the last word are dropped.
        wb[0] = 8'hFF; wb[1] = 8'h00; wb[2] = 8'hFF; wb[3] = 8'hFF;
        ib.cfg_start = 1'b1;
        @(posedge clk); #1;
        ib.cfg_start = 1'b0;
        nd = 0;
        for (int k = 0; k < 4; k++) begin
            ib.cfg_valid = 1'b1;
            ib.cfg_data  = wb[k];
            @(negedge clk);
            chk($sformatf("small_rdy%0d", k), 72'(ib.cfg_ready), 72'h1);
            @(posedge clk); #1;
        end
        ib.cfg_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done_b) nd++;
            @(posedge clk); #1;
        end
        chk("small_c",      72'(c_b), 72'h3FFF00FF);
        chk("small_done_n", 72'(nd),  72'd1);
        chk("small_busy",   72'(busy_b), 72'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
